signed_mac_acc: RTL and testbench

- Parametrised, two-stage pipelined multiply-accumulate.
- The signedness of each operand is selected per beat at run time, so one datapath covers all four cases: signed×signed, signed×unsigned, unsigned×signed and unsigned×unsigned.
- Operand extension, product width and accumulator sign/overflow rules are fixed below.
- Sits behind a valid/ready source and in front of a valid/ready sink in arithmetic datapaths.

---
 rtl/signed_mac_acc_if.sv | 28 ++
 rtl/signed_mac_acc.sv | 98 +++++++++
 tb/tb_signed_mac_acc.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_mac_acc_if.sv
// Valid/ready bundle for signed_mac_acc: operand beat in, running accumulator out.
// master = the side driving operands and out_ready; slave = the MAC itself.
interface signed_mac_acc_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             a_signed;
  logic             b_signed;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, a_signed, b_signed, clear, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, clear, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/signed_mac_acc.sv
// Two-stage pipelined multiply-accumulate with per-beat operand signedness,
// sticky overflow and optional saturation of the signed accumulator.
module signed_mac_acc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  signed_mac_acc_if.slave  bus
);
  localparam int PW = 2*IN_W + 2;
  localparam int XW = (ACC_W > PW) ? ACC_W : PW;

  if (IN_W < 2) begin : g_bad_in_w
    $error("signed_mac_acc: IN_W must be at least 2");
  end
  if (ACC_W < 2*IN_W + 1) begin : g_bad_acc_w
    $error("signed_mac_acc: ACC_W must be at least 2*IN_W+1");
  end

  logic signed [IN_W:0]    a_ext;
  logic signed [IN_W:0]    b_ext;
  logic signed [PW-1:0]    a_wide;
  logic signed [PW-1:0]    b_wide;
  logic signed [PW-1:0]    prod;
  logic signed [XW-1:0]    prod_x;

  logic                    s1_valid;
  logic                    s1_clear;
  logic signed [ACC_W-1:0] s1_prod;

  logic signed [ACC_W-1:0] acc;
  logic                    ovf_q;
  logic                    out_valid_q;

  logic                    adv2;
  logic                    adv1;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum;
  logic                    overflow;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf_next;

  // Extending to IN_W+1 bits lets one signed multiplier cover all four signedness mixes.
  always_comb begin
    a_ext  = {bus.a_signed & bus.a[IN_W-1], bus.a};
    b_ext  = {bus.b_signed & bus.b[IN_W-1], bus.b};
    a_wide = {{(IN_W+1){a_ext[IN_W]}}, a_ext};
    b_wide = {{(IN_W+1){b_ext[IN_W]}}, b_ext};
    prod   = a_wide * b_wide;
    prod_x = XW'(prod);
  end

  always_comb begin
    adv2     = !out_valid_q || bus.out_ready;
    adv1     = !s1_valid || adv2;
    base     = s1_clear ? '0 : acc;
    sum      = {base[ACC_W-1], base} + {s1_prod[ACC_W-1], s1_prod};
    overflow = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next = sum[ACC_W-1:0];
    if (SAT && overflow) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    ovf_next = (s1_clear ? 1'b0 : ovf_q) | overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_clear    <= 1'b0;
      s1_prod     <= '0;
      acc         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (adv2) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          acc   <= acc_next;
          ovf_q <= ovf_next;
        end
      end
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_prod  <= prod_x[ACC_W-1:0];
          s1_clear <= bus.clear;
        end
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_signed_mac_acc.sv
// Directed bench for signed_mac_acc: three instances (24-bit saturating,
// 18-bit saturating, 18-bit wrapping) share one stimulus stream.
module tb_signed_mac_acc;
  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] a         = 8'h00;
  logic [7:0] b         = 8'h00;
  logic       as        = 1'b0;
  logic       bs        = 1'b0;
  logic       clr       = 1'b0;
  logic       out_ready = 1'b1;
  int         total     = 0;
  int         bad       = 0;
  int         xfer      = 0;

  always #5 clk = ~clk;

  signed_mac_acc_if #(.IN_W(8), .ACC_W(24)) if24 ();
  signed_mac_acc_if #(.IN_W(8), .ACC_W(18)) if18s ();
  signed_mac_acc_if #(.IN_W(8), .ACC_W(18)) if18w ();

  assign if24.in_valid  = in_valid;
  assign if24.a         = a;
  assign if24.b         = b;
  assign if24.a_signed  = as;
  assign if24.b_signed  = bs;
  assign if24.clear     = clr;
  assign if24.out_ready = out_ready;

  assign if18s.in_valid  = in_valid;
  assign if18s.a         = a;
  assign if18s.b         = b;
  assign if18s.a_signed  = as;
  assign if18s.b_signed  = bs;
  assign if18s.clear     = clr;
  assign if18s.out_ready = out_ready;

  assign if18w.in_valid  = in_valid;
  assign if18w.a         = a;
  assign if18w.b         = b;
  assign if18w.a_signed  = as;
  assign if18w.b_signed  = bs;
  assign if18w.clear     = clr;
  assign if18w.out_ready = out_ready;

  signed_mac_acc #(.IN_W(8), .ACC_W(24), .SAT(1'b1)) u24 (
    .clk(clk), .rst_n(rst_n), .bus(if24.slave));
  signed_mac_acc #(.IN_W(8), .ACC_W(18), .SAT(1'b1)) u18s (
    .clk(clk), .rst_n(rst_n), .bus(if18s.slave));
  signed_mac_acc #(.IN_W(8), .ACC_W(18), .SAT(1'b0)) u18w (
    .clk(clk), .rst_n(rst_n), .bus(if18w.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] av, input logic [7:0] bv,
                      input logic sa, input logic sb, input logic c);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    as       = sa;
    bs       = sb;
    clr      = c;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  // Signedness flags must be known on every accepted beat.
  always @(posedge clk) begin
    if (rst_n && in_valid && if24.in_ready) begin
      total++;
      assert (!$isunknown({as, bs}))
      else begin
        bad++;
        $error("FAIL flags_known observed=%b expected=known", {as, bs});
      end
    end
  end

  always @(posedge clk) begin
    if (if24.out_valid && if24.out_ready) xfer++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_out_valid", 32'(if24.out_valid), 32'd0);
    chk("rst_acc",       32'(if24.acc_out),   32'd0);
    chk("rst_ovf",       32'(if18s.ovf),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_idle", 32'(if24.in_ready), 32'd1);

    // 24-bit: the four signedness cases
    beat(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    chk("latency_ov0", 32'(if24.out_valid), 32'd0);
    tick();
    chk("uu_acc",  32'(if24.acc_out),   32'h00FE01);
    chk("uu_ovf",  32'(if24.ovf),       32'd0);
    chk("uu_oval", 32'(if24.out_valid), 32'd1);

    beat(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("su_acc", 32'(if24.acc_out), 32'hFFFF01);

    beat(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    chk("ss_acc", 32'(if24.acc_out), 32'h000001);

    beat(8'h80, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("min_acc", 32'(if24.acc_out), 32'hFF8080);
    tick();
    chk("drain_ov0", 32'(if24.out_valid), 32'd0);

    // 18-bit: back-to-back 255*255 overflowing on the third beat
    beat(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    beat(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("s18_r1", 32'(if18s.acc_out), 32'd65025);
    chk("w18_r1", 32'(if18w.acc_out), 32'd65025);
    tick();
    idle();
    chk("s18_r2",     32'(if18s.acc_out), 32'd130050);
    chk("w18_r2_ovf", 32'(if18w.ovf),     32'd0);
    tick();
    chk("s18_r3",     32'(if18s.acc_out), 32'h1FFFF);
    chk("s18_r3_ovf", 32'(if18s.ovf),     32'd1);
    chk("w18_r3",     32'(if18w.acc_out), 32'h2FA03);
    chk("w18_r3_ovf", 32'(if18w.ovf),     32'd1);
    beat(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("s18_clr_acc", 32'(if18s.acc_out), 32'd1);
    chk("s18_clr_ovf", 32'(if18s.ovf),     32'd0);
    chk("w18_clr_ovf", 32'(if18w.ovf),     32'd0);
    tick();
    tick();

    // Backpressure on the 24-bit instance
    xfer = 0;
    beat(8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
    tick();
    beat(8'd2, 8'd1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    tick();
    chk("bp_acc_first", 32'(if24.acc_out),   32'd1);
    chk("bp_oval",      32'(if24.out_valid), 32'd1);
    chk("bp_in_ready0", 32'(if24.in_ready),  32'd0);
    beat(8'd3, 8'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_hold_a", 32'(if24.acc_out),  32'd1);
    chk("bp_hold_r", 32'(if24.in_ready), 32'd0);
    tick();
    tick();
    chk("bp_hold_b", 32'(if24.acc_out),   32'd1);
    chk("bp_hold_v", 32'(if24.out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready1", 32'(if24.in_ready), 32'd1);
    tick();
    chk("bp_out3", 32'(if24.acc_out), 32'd3);
    beat(8'd4, 8'd1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("bp_out6", 32'(if24.acc_out), 32'd6);
    tick();
    chk("bp_out10", 32'(if24.acc_out),   32'd10);
    chk("bp_ov10",  32'(if24.out_valid), 32'd1);
    tick();
    chk("bp_drained", 32'(if24.out_valid), 32'd0);
    chk("bp_xfers",   32'(xfer),           32'd4);

    // Asynchronous reset with both stages full
    beat(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    beat(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    beat(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_ovf", 32'(if18s.ovf), 32'd1);
    out_ready = 1'b0;
    beat(8'h07, 8'h07, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_in_ready", 32'(if18s.in_ready),  32'd0);
    chk("full_oval",     32'(if18s.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_oval", 32'(if18s.out_valid), 32'd0);
    chk("arst_acc",  32'(if18s.acc_out),   32'd0);
    chk("arst_ovf",  32'(if18s.ovf),       32'd0);
    chk("arst_acc24", 32'(if24.acc_out),   32'd0);
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_rst_lat", 32'(if24.out_valid), 32'd0);
    tick();
    chk("post_rst_acc", 32'(if24.acc_out),   32'd6);
    chk("post_rst_ov",  32'(if24.out_valid), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
